// File: rtl/alu_mem_pkg.sv
// Shared definitions for the ALU_Memory burst sequencer: FSM encoding and ALU op codes.
package alu_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [2:0] SEL_AND = 3'b000;
    localparam logic [2:0] SEL_OR  = 3'b001;
    localparam logic [2:0] SEL_ADD = 3'b010;
    localparam logic [2:0] SEL_SUB = 3'b110;
    localparam logic [2:0] SEL_SLT = 3'b111;

endpackage

// File: rtl/beat_counter.sv
// Beat index within a burst; last_o flags the final beat of the latched count.
module beat_counter #(
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_i,
    input  logic          inc_i,
    input  logic [AW-1:0] limit_i,
    output logic [AW-1:0] beat_o,
    output logic          last_o
);

    logic [AW-1:0] beat_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_q <= '0;
        end else if (clr_i) begin
            beat_q <= '0;
        end else if (inc_i) begin
            beat_q <= beat_q + AW'(1);
        end
    end

    assign beat_o = beat_q;
    assign last_o = (beat_q == limit_i);

endmodule

// File: rtl/alu_mem_sequencer.sv
// Drives write/read beat pairs into ALU_Memory, collecting each read-back result
// and tallying zero results over a burst.
//
// state    | meaning
// ST_IDLE  | waiting for Start; command registers load on acceptance
// ST_WRITE | Ewr=1 for the current beat
// ST_READ  | Ewr=0, same address/operands; Mout captured at end of cycle
// ST_DONE  | Done pulse alongside the final ResultValid
module alu_mem_sequencer
    import alu_mem_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int AW    = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Start,
    input  logic [2:0]       SelIn,
    input  logic [WIDTH-1:0] Op1In,
    input  logic [WIDTH-1:0] Op2In,
    input  logic [AW-1:0]    DirIn,
    input  logic [AW-1:0]    CountIn,
    output logic             Ewr,
    output logic [AW-1:0]    Dir,
    output logic [2:0]       Sel,
    output logic [WIDTH-1:0] Op1,
    output logic [WIDTH-1:0] Op2,
    input  logic [WIDTH-1:0] Mout,
    input  logic             Zeroflag,
    output logic             Busy,
    output logic             ResultValid,
    output logic             Done,
    output logic [WIDTH-1:0] Result,
    output logic [AW:0]      ZeroCount
);

    state_e           state_q, state_d;
    logic [2:0]       sel_q;
    logic [WIDTH-1:0] op1_q, op2_q, result_q;
    logic [AW-1:0]    base_q, count_q;
    logic [AW:0]      zc_q;
    logic             rv_q;
    logic [AW-1:0]    beat;
    logic             last_beat;
    logic             accept;
    logic             read_end;

    assign accept   = (state_q == ST_IDLE) && Start;
    assign read_end = (state_q == ST_READ);

    beat_counter #(.AW(AW)) u_beat (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (accept),
        .inc_i   (read_end && !last_beat),
        .limit_i (count_q),
        .beat_o  (beat),
        .last_o  (last_beat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (Start) state_d = ST_WRITE;
            ST_WRITE: state_d = ST_READ;
            ST_READ:  state_d = last_beat ? ST_DONE : ST_WRITE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q    <= '0;
            op1_q    <= '0;
            op2_q    <= '0;
            base_q   <= '0;
            count_q  <= '0;
            result_q <= '0;
            zc_q     <= '0;
            rv_q     <= 1'b0;
        end else begin
            rv_q <= read_end;
            if (accept) begin
                sel_q   <= SelIn;
                op1_q   <= Op1In;
                op2_q   <= Op2In;
                base_q  <= DirIn;
                count_q <= CountIn;
                zc_q    <= '0;
            end
            if (read_end) begin
                result_q <= Mout;
                if (Zeroflag) zc_q <= zc_q + (AW+1)'(1);
            end
        end
    end

    // Address and Op2 track the beat combinationally so READ sees the WRITE values.
    assign Ewr         = (state_q == ST_WRITE);
    assign Dir         = base_q + beat;
    assign Sel         = sel_q;
    assign Op1         = op1_q;
    assign Op2         = op2_q + WIDTH'(beat);
    assign Busy        = (state_q != ST_IDLE);
    assign Done        = (state_q == ST_DONE);
    assign ResultValid = rv_q;
    assign Result      = result_q;
    assign ZeroCount   = zc_q;

endmodule

// File: tb/tb_alu_mem_sequencer.sv
// Bench for alu_mem_sequencer with a behavioural ALU_Memory responder and a
// command-level timing model checked on every cycle.
module tb_alu_mem_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        Start = 1'b0;
    logic [2:0]  SelIn = '0;
    logic [31:0] Op1In = '0, Op2In = '0;
    logic [4:0]  DirIn = '0, CountIn = '0;
    logic        Ewr, Zeroflag, Busy, ResultValid, Done;
    logic [4:0]  Dir;
    logic [2:0]  Sel;
    logic [31:0] Op1, Op2, Mout, Result;
    logic [5:0]  ZeroCount;

    always #5 clk = ~clk;

    alu_mem_sequencer #(.WIDTH(32), .AW(5)) dut (
        .clk(clk), .rst_n(rst_n), .Start(Start), .SelIn(SelIn),
        .Op1In(Op1In), .Op2In(Op2In), .DirIn(DirIn), .CountIn(CountIn),
        .Ewr(Ewr), .Dir(Dir), .Sel(Sel), .Op1(Op1), .Op2(Op2),
        .Mout(Mout), .Zeroflag(Zeroflag), .Busy(Busy), .ResultValid(ResultValid),
        .Done(Done), .Result(Result), .ZeroCount(ZeroCount)
    );

    function automatic logic [31:0] alu_f(logic [2:0] s, logic [31:0] a, logic [31:0] b);
        case (s)
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b010:  return a + b;
            3'b110:  return a - b;
            3'b111:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    // ALU_Memory responder: write on Ewr, asynchronous read of the addressed word
    logic [31:0] mem [32];
    initial for (int i = 0; i < 32; i++) mem[i] = '0;
    always @(posedge clk) if (Ewr) mem[Dir] <= alu_f(Sel, Op1, Op2);
    assign Mout     = mem[Dir];
    assign Zeroflag = (alu_f(Sel, Op1, Op2) == 32'd0);

    int n_cmp = 0, n_mis = 0;
    int cyc = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Command model: t0 is the cycle in which Start was accepted
    bit          m_active = 0;
    int          t0 = 0, m_n = 1, m_zc = 0;
    logic [2:0]  m_sel;
    logic [31:0] m_op1, m_op2;
    logic [4:0]  m_dir;
    logic [31:0] m_res [32];

    function automatic bit m_busy();
        return m_active && (cyc - t0) >= 1 && (cyc - t0) <= 2 * m_n + 1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 0;
        end else begin
            if (Start && !m_busy()) begin
                m_sel = SelIn; m_op1 = Op1In; m_op2 = Op2In; m_dir = DirIn;
                m_n = int'(CountIn) + 1;
                m_zc = 0;
                for (int b = 0; b < m_n; b++) begin
                    m_res[b] = alu_f(m_sel, m_op1, m_op2 + 32'(b));
                    if (m_res[b] == 32'd0) m_zc++;
                end
                t0 = cyc;
                m_active = 1;
            end
            cyc = cyc + 1;
        end
    end

    task automatic chk_all_zero(string tag);
        chk({tag, "_ewr"}, 64'(Ewr), 0);
        chk({tag, "_dir"}, 64'(Dir), 0);
        chk({tag, "_sel"}, 64'(Sel), 0);
        chk({tag, "_op1"}, 64'(Op1), 0);
        chk({tag, "_op2"}, 64'(Op2), 0);
        chk({tag, "_result"}, 64'(Result), 0);
        chk({tag, "_zc"}, 64'(ZeroCount), 0);
        chk({tag, "_busy"}, 64'(Busy), 0);
        chk({tag, "_rv"}, 64'(ResultValid), 0);
        chk({tag, "_done"}, 64'(Done), 0);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            chk_all_zero("rst");
        end else begin
            int rel, b;
            bit act;
            rel = cyc - t0;
            act = m_active && rel >= 1 && rel <= 2 * m_n + 1;
            chk("busy", 64'(Busy), 64'(act));
            if (act) begin
                chk("ewr", 64'(Ewr), 64'(rel <= 2 * m_n && rel % 2 == 1));
                chk("done", 64'(Done), 64'(rel == 2 * m_n + 1));
                chk("rv", 64'(ResultValid), 64'(rel >= 3 && rel % 2 == 1));
                if (rel <= 2 * m_n) begin
                    b = (rel - 1) / 2;
                    chk("dir", 64'(Dir), 64'(5'(m_dir + 5'(b))));
                    chk("sel", 64'(Sel), 64'(m_sel));
                    chk("op1", 64'(Op1), 64'(m_op1));
                    chk("op2", 64'(Op2), 64'(32'(m_op2 + 32'(b))));
                end
                if (rel >= 3 && rel % 2 == 1)
                    chk("result", 64'(Result), 64'(m_res[(rel - 3) / 2]));
                if (rel == 2 * m_n + 1)
                    chk("zerocount", 64'(ZeroCount), 64'(m_zc));
            end else begin
                chk("ewr_idle", 64'(Ewr), 0);
                chk("done_idle", 64'(Done), 0);
                chk("rv_idle", 64'(ResultValid), 0);
            end
        end
    end

    // Capture for directed literal checks
    logic [4:0]  wr_q [$];
    logic [31:0] res_q [$];
    bit          done_seen = 0;
    int          done_cyc = 0, s_cyc = 0;
    logic [5:0]  zc_done;

    always @(negedge clk) begin
        if (rst_n && Ewr) wr_q.push_back(Dir);
        if (rst_n && ResultValid) res_q.push_back(Result);
        if (rst_n && Done) begin
            done_seen = 1; done_cyc = cyc; zc_done = ZeroCount;
        end
    end

    task automatic issue(logic [2:0] s, logic [31:0] a, logic [31:0] b,
                         logic [4:0] d, logic [4:0] c, bit poke);
        @(posedge clk); #1;
        wr_q.delete(); res_q.delete(); done_seen = 0;
        SelIn = s; Op1In = a; Op2In = b; DirIn = d; CountIn = c; Start = 1;
        s_cyc = cyc;
        for (int i = 0; i < 80 && !done_seen; i++) begin
            @(posedge clk); #1;
            Start = 0;
            if (poke && i == 2) begin
                Start = 1; SelIn = 3'b010; Op1In = 32'd7; Op2In = 32'd9;
                DirIn = 5'd3; CountIn = 5'd0;
            end
        end
        Start = 0;
        chk("done_seen", 64'(done_seen), 1);
    endtask

    function automatic logic [63:0] qr(int i);
        return (res_q.size() > i) ? 64'(res_q[i]) : 64'hBAD0_BAD0_BAD0_BAD0;
    endfunction
    function automatic logic [63:0] qw(int i);
        return (wr_q.size() > i) ? 64'(wr_q[i]) : 64'hBAD0_BAD0_BAD0_BAD0;
    endfunction

    task automatic chk_burst_sub(string tag);
        chk({tag, "_nwr"}, 64'(wr_q.size()), 4);
        chk({tag, "_d0"}, qw(0), 30);
        chk({tag, "_d1"}, qw(1), 31);
        chk({tag, "_d2"}, qw(2), 0);
        chk({tag, "_d3"}, qw(3), 1);
        chk({tag, "_r0"}, qr(0), 2);
        chk({tag, "_r1"}, qr(1), 1);
        chk({tag, "_r2"}, qr(2), 0);
        chk({tag, "_r3"}, qr(3), 64'h0000_0000_FFFF_FFFF);
        chk({tag, "_zc"}, 64'(zc_done), 1);
        chk({tag, "_lat"}, 64'(done_cyc - s_cyc), 9);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1;

        issue(3'b111, 32'd1050, 32'd1150, 5'd1, 5'd0, 0);
        chk("slt_nwr", 64'(wr_q.size()), 1);
        chk("slt_dir", qw(0), 1);
        chk("slt_res", qr(0), 1);
        chk("slt_zc", 64'(zc_done), 0);
        chk("slt_lat", 64'(done_cyc - s_cyc), 3);

        issue(3'b110, 32'd1050, 32'd1150, 5'd15, 5'd0, 0);
        chk("sub_res", qr(0), 64'h0000_0000_FFFF_FF9C);
        chk("sub_zc", 64'(zc_done), 0);

        issue(3'b110, 32'd1152, 32'd1150, 5'd30, 5'd3, 0);
        chk_burst_sub("burst");

        issue(3'b110, 32'd1152, 32'd1150, 5'd30, 5'd3, 1);
        chk_burst_sub("poke");

        issue(3'b010, 32'hFFFF_FFFF, 32'd1, 5'd31, 5'd0, 0);
        chk("addwrap_res", qr(0), 0);
        chk("addwrap_zc", 64'(zc_done), 1);

        // Reset during READ of beat 2 of a 4-beat burst
        @(posedge clk); #1;
        done_seen = 0;
        SelIn = 3'b010; Op1In = 32'd100; Op2In = 32'd5; DirIn = 5'd3; CountIn = 5'd3; Start = 1;
        @(posedge clk); #1 Start = 0;
        repeat (3) @(posedge clk);
        #1 chk("pre_rst_read", 64'({Busy, Ewr}), 64'b10);
        rst_n = 0;
        #1 chk_all_zero("rst_imm");
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        repeat (3) @(posedge clk);
        chk("no_done_abort", 64'(done_seen), 0);

        issue(3'b010, 32'd7, 32'd8, 5'd2, 5'd1, 0);
        chk("after_rst_r0", qr(0), 15);
        chk("after_rst_r1", qr(1), 16);
        chk("after_rst_lat", 64'(done_cyc - s_cyc), 5);

        // Randomized traffic with Start pokes while busy and occasional resets
        for (int i = 0; i < 1500; i++) begin
            logic [2:0] codes [5];
            codes[0] = 3'b000; codes[1] = 3'b001; codes[2] = 3'b010;
            codes[3] = 3'b110; codes[4] = 3'b111;
            @(posedge clk); #1;
            if (!rst_n) rst_n = 1;
            else if ($urandom_range(0, 249) == 0) rst_n = 0;
            Start   = ($urandom_range(0, 3) == 0);
            SelIn   = codes[$urandom_range(0, 4)];
            Op2In   = ($urandom_range(0, 1) == 0) ? $urandom : $urandom_range(0, 20);
            Op1In   = ($urandom_range(0, 2) == 0) ? Op2In + $urandom_range(0, 3) : $urandom;
            DirIn   = 5'($urandom);
            CountIn = 5'($urandom_range(0, 7));
        end
        @(posedge clk); #1;
        Start = 0; rst_n = 1;
        repeat (40) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
